// File: rtl/attention_score_unit.sv
// Serial Q.K dot product (one MAC per cycle), scaled by ~1/sqrt(N_ELEM) and saturated to ELEM_W bits.
// Optional build macro SCORE_ROUND_EN: round-half-up before saturation instead of floor.
module attention_score_unit #(
  parameter int ELEM_W      = 16,
  parameter int N_ELEM      = 12,
  parameter int ACC_W       = 40,
  parameter int SCALE_MUL   = 37,
  parameter int SCALE_SHIFT = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_ELEM*ELEM_W-1:0]   q_vec,
  input  logic [N_ELEM*ELEM_W-1:0]   k_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [ELEM_W-1:0]   score,
  output logic                       overflow
);

  localparam int PW    = ACC_W + 7;
  localparam int IDX_W = $clog2(N_ELEM);
  localparam logic signed [PW-1:0] SCALE_K = PW'(SCALE_MUL);
  localparam logic signed [PW-1:0] SAT_MAX = PW'((2 ** (ELEM_W - 1)) - 1);
  localparam logic signed [PW-1:0] SAT_MIN = -PW'(2 ** (ELEM_W - 1));
`ifdef SCORE_ROUND_EN
  localparam logic signed [PW-1:0] RND_K   = PW'(2 ** (SCALE_SHIFT - 1));
`endif

  typedef enum logic [1:0] {IDLE, MAC, SCALE, OUT} state_t;

  state_t                    state, state_nxt;
  logic signed [ELEM_W-1:0]  q_mem [N_ELEM];
  logic signed [ELEM_W-1:0]  k_mem [N_ELEM];
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic signed [2*ELEM_W-1:0] prod;
  logic [ELEM_W:0]           sat_res;
  logic                      last_idx;

  // Returns {overflow, score}: scale the accumulator, shift down, clamp to ELEM_W.
  function automatic logic [ELEM_W:0] scale_sat(input logic signed [ACC_W-1:0] a);
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] s;
    p = PW'(a) * SCALE_K;
`ifdef SCORE_ROUND_EN
    p = p + RND_K;
`endif
    s = p >>> SCALE_SHIFT;
    if (s > SAT_MAX)
      return {1'b1, SAT_MAX[ELEM_W-1:0]};
    else if (s < SAT_MIN)
      return {1'b1, SAT_MIN[ELEM_W-1:0]};
    else
      return {1'b0, s[ELEM_W-1:0]};
  endfunction

  assign prod     = q_mem[idx] * k_mem[idx];
  assign last_idx = (idx == IDX_W'(N_ELEM - 1));
  assign sat_res  = scale_sat(acc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = MAC;
      end
      MAC: begin
        if (last_idx)
          state_nxt = SCALE;
      end
      SCALE: state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture: vectors are only read during MAC, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      for (int i = 0; i < N_ELEM; i++) begin
        q_mem[i] <= q_vec[i*ELEM_W +: ELEM_W];
        k_mem[i] <= k_vec[i*ELEM_W +: ELEM_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      idx      <= '0;
      score    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc <= '0;
            idx <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          idx <= idx + 1'b1;
        end
        SCALE: {overflow, score} <= sat_res;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_attention_score_unit.sv
// Directed bench for attention_score_unit with a queue-based scoreboard of expected scores.
module tb_attention_score_unit;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [191:0] q_vec;
  logic [191:0] k_vec;
  logic         out_valid;
  logic         out_ready;
  logic signed [15:0] score;
  logic         overflow;

  logic [16:0]  exp_q[$];
  int           errors = 0;
  int           checks = 0;

  attention_score_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .q_vec     (q_vec),
    .k_vec     (k_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .score     (score),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product, x37, optional +64, floor shift by 7, clamp.
  function automatic logic [16:0] model(input logic [191:0] qv, input logic [191:0] kv);
    longint acc;
    longint p;
    longint s;
    logic [63:0] su;
    acc = 0;
    for (int i = 0; i < 12; i++)
      acc += longint'($signed(qv[16*i +: 16])) * longint'($signed(kv[16*i +: 16]));
    p = acc * 37;
`ifdef SCORE_ROUND_EN
    p = p + 64;
`endif
    s = p >>> 7;
    su = s;
    if (s > 32767) return {1'b1, 16'h7fff};
    if (s < -32768) return {1'b1, 16'h8000};
    return {1'b0, su[15:0]};
  endfunction

  function automatic logic [191:0] fill(input logic [15:0] v);
    logic [191:0] r;
    for (int i = 0; i < 12; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  // Returns just after the accepting rising edge.
  task automatic send(input logic [191:0] qv, input logic [191:0] kv);
    int n;
    n = 0;
    @(negedge clk);
    q_vec = qv;
    k_vec = kv;
    in_valid = 1'b1;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", {15'd0, in_ready}, 16'd1);
    exp_q.push_back(model(qv, kv));
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag);
    logic [16:0] e;
    chk({tag, "_queue"}, {15'd0, exp_q.size() != 0}, 16'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_score"}, score, e[15:0]);
      chk({tag, "_ovf"}, {15'd0, overflow}, {15'd0, e[16]});
    end
  endtask

  // Called right after the accept edge; waits for the result, optionally stalls, then handshakes.
  task automatic collect(input string tag, input int stall);
    int n;
    logic [15:0] s0;
    logic o0;
    n = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, 16'(n), 16'd13);
    if (!out_valid) return;
    s0 = score;
    o0 = overflow;
    for (int i = 0; i < stall; i++) begin
      if (i == 1) begin
        q_vec = fill(16'h0100);
        k_vec = fill(16'h0100);
        in_valid = 1'b1;
      end
      if (i == 3) in_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_stall_valid"}, {15'd0, out_valid}, 16'd1);
      chk({tag, "_stall_score"}, score, s0);
      chk({tag, "_stall_ovf"}, {15'd0, overflow}, {15'd0, o0});
      chk({tag, "_stall_inrdy"}, {15'd0, in_ready}, 16'd0);
    end
    check_out(tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, {15'd0, out_valid}, 16'd0);
    chk({tag, "_inrdy_back"}, {15'd0, in_ready}, 16'd1);
    if (stall > 0) begin
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_no_capture"}, {15'd0, in_ready}, 16'd1);
    end
  endtask

  initial begin
    logic [191:0] qa;
    logic [191:0] ka;
    logic [191:0] qb;
    logic [191:0] kb;
    int t;
    int acc_at;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    q_vec = '0;
    k_vec = '0;
    #12;
    chk("rst_in_ready", {15'd0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
    chk("rst_score", score, 16'd0);
    chk("rst_ovf", {15'd0, overflow}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    send(fill(16'd2), fill(16'd2));
    collect("two_two", 0);

    for (int i = 0; i < 12; i++) qa[16*i +: 16] = 16'(i + 1);
    send(qa, fill(16'd1));
    collect("ramp", 0);

    send(fill(-16'sd2), fill(16'd2));
    collect("neg", 0);

    send(fill(16'h7fff), fill(16'h7fff));
    collect("sat_pos", 0);

    send(fill(16'h7fff), fill(16'h8000));
    collect("sat_neg", 0);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        qa[16*i +: 16] = 16'($urandom);
        ka[16*i +: 16] = 16'($urandom_range(0, 2047));
      end
      send(qa, ka);
      collect("rand", 0);
    end

    for (int i = 0; i < 12; i++) begin
      qa[16*i +: 16] = 16'($urandom_range(0, 4000));
      ka[16*i +: 16] = 16'(-$urandom_range(0, 4000));
    end
    send(qa, ka);
    collect("stall", 5);

    // Back-to-back: second pair offered right after the first is accepted.
    for (int i = 0; i < 12; i++) begin
      qa[16*i +: 16] = 16'(3 * i - 7);
      ka[16*i +: 16] = 16'(100 + i);
      qb[16*i +: 16] = 16'(-50 * i);
      kb[16*i +: 16] = 16'(i + 9);
    end
    send(qa, ka);
    out_ready = 1'b1;
    q_vec = qb;
    k_vec = kb;
    in_valid = 1'b1;
    t = 0;
    acc_at = -1;
    while (t < 40) begin
      @(negedge clk);
      if (out_valid) check_out("b2b_a");
      if (in_ready) begin
        exp_q.push_back(model(qb, kb));
        acc_at = t + 1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        break;
      end
      @(posedge clk);
      t++;
    end
    chk("b2b_spacing", 16'(acc_at), 16'd15);
    collect("b2b_b", 0);

    // Reset in the middle of MAC aborts cleanly.
    send(fill(16'd1000), fill(16'd1000));
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out_valid", {15'd0, out_valid}, 16'd0);
    chk("abort_score", score, 16'd0);
    chk("abort_in_ready", {15'd0, in_ready}, 16'd1);
    void'(exp_q.pop_back());
    @(negedge clk);
    rst = 1'b0;
    send(fill(16'd3), fill(-16'sd5));
    collect("after_abort", 0);

    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/attention_score_unit.md
Name: attention_score_unit

Overview:
Downstream consumer of the QKV generator in the Fusion Core. It takes one Q vector and one K vector, each 12 x 16-bit signed. It computes their dot product serially, one MAC per cycle, then scales the result by approx. 1/sqrt(12) and saturates it to a 16-bit signed attention score for the softmax stage. Input and output use valid/ready handshakes, and one vector pair is processed at a time.

Parameters:
ELEM_W, 16, element width in bits (signed two's complement)
N_ELEM, 12, elements per vector
ACC_W, 40, accumulator width in bits (signed)
SCALE_MUL, 37, scale numerator (37/128 = 0.289, approx. 1/sqrt(12))
SCALE_SHIFT, 7, scale right-shift amount

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  q_vec/k_vec valid
in_ready  output  1  unit can accept a pair
q_vec  input  N_ELEM*ELEM_W (192)  Q vector; element i at bits [16i+15:16i]
k_vec  input  N_ELEM*ELEM_W (192)  K vector; same packing as q_vec
out_valid  output  1  score valid
out_ready  input  1  downstream accepts score
score  output  ELEM_W (16)  scaled, saturated signed score
overflow  output  1  high if score was saturated; qualified by out_valid

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, score=0, overflow=0, accumulator=0, index=0. Reset asserted in any state aborts the current operation; no partial result is ever emitted.
- FSM states are IDLE, MAC, SCALE, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: register q_vec and k_vec, clear acc and idx, go to MAC.
  - Input vectors are not used after capture.
- MAC:
  - in_ready=0.
  - Each cycle: acc += sext(q[idx]) * sext(k[idx]) at full ACC_W precision; idx++.
  - After idx = N_ELEM-1 is processed (12 cycles), go to SCALE.
  - acc cannot overflow 40 bits: max |sum| = 12 * 2^30.
- SCALE (1 cycle):
  - p = acc * SCALE_MUL, computed in ACC_W+7 bits signed.
  - s = p >>> SCALE_SHIFT (arithmetic shift, i.e. floor).
  - If s > 32767: score=32767, overflow=1.
  - If s < -32768: score=-32768, overflow=1.
  - Otherwise score=s[15:0], overflow=0.
  - Go to OUT.
- OUT:
  - out_valid=1; score and overflow are held stable until out_ready=1.
  - On the handshake: out_valid falls next cycle and state returns to IDLE.
  - in_ready stays 0 throughout OUT; there is no overlap between output and input.
- Latency: the accept edge is cycle 0, and out_valid is high after the edge of cycle 13 (13 cycles).
- Minimum issue interval: 15 cycles per pair with out_ready held at 1.
- in_valid while in_ready=0 is ignored. The upstream must hold its data until it sees in_ready.
- score and overflow change only on the SCALE-cycle edge or on reset.

Optional Feature:
- Macro: SCORE_ROUND_EN.
- Defined: SCALE computes s = (p + 2^(SCALE_SHIFT-1)) >>> SCALE_SHIFT, i.e. round-half-up, before saturation.
- Undefined: s = p >>> SCALE_SHIFT (floor).
- Latency and interface are identical in both builds.

Test Plan:
- All q=2, k=2 -> acc=48, p=1776. Without SCORE_ROUND_EN: score=13, overflow=0. With SCORE_ROUND_EN: score=14. out_valid appears 13 cycles after accept.
- q[i]=i+1, all k=1 -> acc=78. Without SCORE_ROUND_EN: score=22. With SCORE_ROUND_EN: score=23. overflow=0.
- All q=-2, all k=2 -> acc=-48. Score=-14 in both builds, overflow=0.
- All q=32767, all k=32767 -> score=32767, overflow=1. All q=32767, all k=-32768 -> score=-32768, overflow=1.
- Hold out_ready=0 for 5 cycles in OUT -> score/overflow stable, in_ready=0, and a new in_valid is ignored. Then assert out_ready -> out_valid drops next cycle and in_ready=1. Two back-to-back pairs are spaced 15 cycles apart.
- Assert rst during MAC (idx=6) -> out_valid=0, score=0, in_ready=1 immediately. The next pair gives the correct result with no carry-over of the accumulator.
